avmm_csr_slave: RTL and testbench
=================================

AVMM_CSR_SLAVE -- requirements
Module: avmm_csr_slave

Interface
REQ-001 SHALL have parameter AVMM_WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter BYTE_WIDTH, default 4, byteenable width; AVMM_WIDTH = 8*BYTE_WIDTH.
REQ-003 SHALL have parameter NUM_REGS, default 32, number of word registers (2..64).
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, extra waitrequest-high cycles before accept (0..15).
REQ-005 SHALL have parameter RD_LATENCY, default 2, accept-to-readdatavalid cycles (1..8).
REQ-006 SHALL have parameter ID_VALUE, default 32'hA1B0_0001, contents of register 0.
REQ-007 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have port address  in  17  byte address; register index = address[16:2].
REQ-010 SHALL have port read  in  1  read command.
REQ-011 SHALL have port write  in  1  write command.
REQ-012 SHALL have port writedata  in  AVMM_WIDTH  write data.
REQ-013 SHALL have port byteenable  in  BYTE_WIDTH  per-byte write enables.
REQ-014 SHALL have port readdata  out  AVMM_WIDTH  read data.
REQ-015 SHALL have port readdatavalid  out  1  one-cycle read-return strobe.
REQ-016 SHALL have port waitrequest  out  1  high = command not accepted.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACCEPT, RDPEND.
REQ-018 IDLE: waitrequest=1; read or write sampled high -> WAIT if WAIT_CYCLES>0, else ACCEPT.
REQ-019 WAIT: counts WAIT_CYCLES cycles with waitrequest=1, then -> ACCEPT; command dropped (read=write=0) -> IDLE, no side effect.
REQ-020 ACCEPT: waitrequest=0 for exactly one cycle; the command is executed at the rising edge that ends this cycle.
REQ-021 Write accept: each byte i of the addressed register updated from writedata only where byteenable[i]=1; next state IDLE.
REQ-022 Read accept: addressed register value captured; next state RDPEND.
REQ-023 RDPEND: waitrequest=1; readdatavalid=1 for one cycle exactly RD_LATENCY cycles after the accept edge; then -> IDLE.
REQ-024 readdata SHALL hold its last returned value until the next read return.
REQ-025 Register 0 is read-only, returns ID_VALUE; writes to it are silently dropped.
REQ-026 Registers 1..NUM_REGS-1 are read/write.
REQ-027 Index >= NUM_REGS is out of range: writes dropped, reads return 0, handshake identical to in-range.
REQ-028 read and write both high at accept: treated as write, read ignored, no readdatavalid.
REQ-029 Commands arriving in RDPEND SHALL stall (waitrequest=1) until IDLE is re-entered.
REQ-030 A write accepted in the same cycle pattern as a preceding read SHALL NOT alter that read's already-captured data.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, waitrequest=1, readdatavalid=0, readdata=0, registers 1..NUM_REGS-1 = 0, wait counter 0.
REQ-032 Reset during WAIT, ACCEPT or RDPEND SHALL abort the transaction with no register update and no readdatavalid.

Configuration
REQ-033 Macro AVMM_CSR_SLAVE_ERR_EN defined: adds output err_count (8 bits, reset 0), incremented on every accepted out-of-range access, saturating at 255; out-of-range reads return 32'hBADA_DD00.
REQ-034 Macro undefined: no err_count port, out-of-range behaviour per REQ-027.

Verification
REQ-035 Write addr 0x004 be=0xF data 0x12345678, then read 0x004 -> waitrequest low 1 cycle after WAIT_CYCLES; readdatavalid 2 cycles after read accept; readdata 0x12345678.
REQ-036 Write addr 0x008 data 0xFFFFFFFF be=0xF, then data 0x00000000 be=0x5; read 0x008 -> 0xFF00FF00.
REQ-037 Write 0x0 data 0 then read 0x0 -> 0xA1B00001.
REQ-038 Read 0x200 (index 128) -> 0 without macro; 0xBADADD00 and err_count 1 with AVMM_CSR_SLAVE_ERR_EN.
REQ-039 Issue read 0x004, assert rst_n low during RDPEND -> readdatavalid never pulses, waitrequest=1, readdata=0, register 1 reads 0 after reset.
REQ-040 Assert write for 1 cycle then drop during WAIT (WAIT_CYCLES=3) -> FSM returns IDLE, target register unchanged.

Source files
------------

// File: rtl/avmm_csr_slave.sv
// avmm_csr_slave: Avalon-MM CSR slave with a word-addressed register file.
// Register 0 is a read-only ID word, registers 1..NUM_REGS-1 are read/write.
// Each command sees WAIT_CYCLES extra waitrequest-high cycles before it is
// accepted. A read returns data RD_LATENCY cycles after its accept edge.
// Optional build macro AVMM_CSR_SLAVE_ERR_EN adds an err_count output that
// counts out-of-range accesses. With it, out-of-range reads return 0xBADADD00.
module avmm_csr_slave #(
    parameter int AVMM_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 4,
    parameter int NUM_REGS    = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int RD_LATENCY  = 2,
    parameter logic [AVMM_WIDTH-1:0] ID_VALUE = AVMM_WIDTH'(32'hA1B0_0001)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [16:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [AVMM_WIDTH-1:0] writedata,
    input  logic [BYTE_WIDTH-1:0] byteenable,
    output logic [AVMM_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest
`ifdef AVMM_CSR_SLAVE_ERR_EN
    ,
    output logic [7:0]            err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_RDPEND = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [3:0] LAT_LOAD  = 4'(RD_LATENCY - 1);

`ifdef AVMM_CSR_SLAVE_ERR_EN
    localparam logic [AVMM_WIDTH-1:0] OOR_VALUE = AVMM_WIDTH'(32'hBADA_DD00);
`else
    localparam logic [AVMM_WIDTH-1:0] OOR_VALUE = '0;
`endif

    state_t                  state_q;
    logic [3:0]              wait_cnt_q;
    logic [3:0]              lat_cnt_q;
    logic                    waitrequest_q;
    logic                    rdv_q;
    logic [AVMM_WIDTH-1:0]   readdata_q;
    logic [AVMM_WIDTH-1:0]   rd_capture_q;
    logic [AVMM_WIDTH-1:0]   regs_q [1:NUM_REGS-1];

    logic [14:0]             reg_idx;
    logic                    in_range;
    logic                    cmd;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [AVMM_WIDTH-1:0]   rd_word;
    logic                    unused_addr_bits;

    assign reg_idx          = address[16:2];
    assign unused_addr_bits = ^address[1:0];
    assign in_range         = (reg_idx < 15'(NUM_REGS));
    assign cmd              = read | write;
    // Write wins when both commands are present at the accept edge.
    assign wr_fire          = (state_q == ST_ACCEPT) && write;
    assign rd_fire          = (state_q == ST_ACCEPT) && read && !write;

    assign waitrequest      = waitrequest_q;
    assign readdatavalid    = rdv_q;
    assign readdata         = readdata_q;

    // Read mux: ID word, register file, or the out-of-range value.
    always_comb begin
        rd_word = in_range ? '0 : OOR_VALUE;
        if (reg_idx == 15'd0) begin
            rd_word = ID_VALUE;
        end
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (reg_idx == 15'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    // Register file: byte-masked update on an accepted in-range write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (reg_idx == 15'(i)) begin
                    for (int unsigned b = 0; b < BYTE_WIDTH; b++) begin
                        if (byteenable[b]) begin
                            regs_q[i][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Handshake FSM with registered waitrequest, readdatavalid and readdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            lat_cnt_q     <= '0;
            waitrequest_q <= 1'b1;
            rdv_q         <= 1'b0;
            readdata_q    <= '0;
            rd_capture_q  <= '0;
        end else begin
            waitrequest_q <= 1'b1;
            rdv_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd) begin
                        if (WAIT_CYCLES > 0) begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= WAIT_LOAD;
                        end else begin
                            state_q       <= ST_ACCEPT;
                            waitrequest_q <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cmd) begin
                        state_q <= ST_IDLE;
                    end else if (wait_cnt_q == '0) begin
                        state_q       <= ST_ACCEPT;
                        waitrequest_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_ACCEPT: begin
                    if (rd_fire) begin
                        rd_capture_q <= rd_word;
                        lat_cnt_q    <= LAT_LOAD;
                        state_q      <= ST_RDPEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RDPEND: begin
                    if (lat_cnt_q == '0) begin
                        rdv_q      <= 1'b1;
                        readdata_q <= rd_capture_q;
                        state_q    <= ST_IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AVMM_CSR_SLAVE_ERR_EN
    logic [7:0] err_count_q;

    assign err_count = err_count_q;

    // Saturating count of accepted out-of-range accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if ((state_q == ST_ACCEPT) && cmd && !in_range && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avmm_csr_slave.sv
// tb_avmm_csr_slave: directed and random transactions against avmm_csr_slave.
// The expected values come from a word-array model of the register map.
module tb_avmm_csr_slave;

    localparam int AW = 32;
    localparam int BW = 4;
    localparam int NR = 32;
    localparam int WC = 3;
    localparam int RL = 2;
    localparam logic [31:0] IDV = 32'hA1B0_0001;

    logic          clk;
    logic          rst_n;
    logic [16:0]   address;
    logic          read;
    logic          write;
    logic [AW-1:0] writedata;
    logic [BW-1:0] byteenable;
    logic [AW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
`ifdef AVMM_CSR_SLAVE_ERR_EN
    logic [7:0]    err_count;
    int            exp_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NR];

    avmm_csr_slave #(
        .AVMM_WIDTH (AW),
        .BYTE_WIDTH (BW),
        .NUM_REGS   (NR),
        .WAIT_CYCLES(WC),
        .RD_LATENCY (RL),
        .ID_VALUE   (IDV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .waitrequest  (waitrequest)
`ifdef AVMM_CSR_SLAVE_ERR_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_read(input int unsigned idx);
        if (idx == 0) return IDV;
`ifdef AVMM_CSR_SLAVE_ERR_EN
        if (idx >= NR) return 32'hBADA_DD00;
`else
        if (idx >= NR) return 32'h0;
`endif
        return model[idx];
    endfunction

    function automatic void ref_write(input int unsigned idx, input logic [31:0] data,
                                      input logic [3:0] be);
        logic [31:0] m;
        if (idx == 0 || idx >= NR) return;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        model[idx] = (model[idx] & ~m) | (data & m);
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
`ifdef AVMM_CSR_SLAVE_ERR_EN
        exp_err = 0;
`endif
    endfunction

    // One complete transaction from an idle slave, with handshake timing checks.
    task automatic do_access(input logic is_wr, input logic also_rd, input logic [16:0] addr,
                             input logic [31:0] data, input logic [3:0] be, input string tag);
        int n;
        int m;
        int unsigned idx;
        logic [31:0] exp;
        logic saw_rdv;
        idx        = int'(addr[16:2]);
        exp        = ref_read(idx);
        address    = addr;
        writedata  = data;
        byteenable = be;
        write      = is_wr;
        read       = !is_wr || also_rd;
        n = 0;
        while (waitrequest === 1'b1 && n < 64) begin
            step();
            n++;
        end
        check({tag, " accept-latency"}, 32'(n), 32'(WC + 1));
        step();
        read  = 1'b0;
        write = 1'b0;
        check({tag, " waitrequest-after-accept"}, 32'(waitrequest), 32'd1);
`ifdef AVMM_CSR_SLAVE_ERR_EN
        if (idx >= NR && exp_err < 255) exp_err++;
        check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
`endif
        if (is_wr) begin
            ref_write(idx, data, be);
            if (also_rd) begin
                saw_rdv = 1'b0;
                for (int k = 0; k < RL + 3; k++) begin
                    if (readdatavalid !== 1'b0) saw_rdv = 1'b1;
                    step();
                end
                check({tag, " no-rdv-on-write"}, 32'(saw_rdv), 32'd0);
            end
        end else begin
            m = 0;
            while (readdatavalid !== 1'b1 && m < 64) begin
                step();
                m++;
            end
            check({tag, " rd-latency"}, 32'(m), 32'(RL));
            check({tag, " readdata"}, readdata, exp);
            step();
            check({tag, " rdv-one-cycle"}, 32'(readdatavalid), 32'd0);
            check({tag, " readdata-hold"}, readdata, exp);
        end
    endtask

    initial begin
        int n;
        int unsigned idx;
        logic is_wr;
        logic flag;

        rst_n      = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        ref_reset();
        step();
        step();
        check("reset waitrequest", 32'(waitrequest), 32'd1);
        check("reset readdatavalid", 32'(readdatavalid), 32'd0);
        check("reset readdata", readdata, 32'h0);
        rst_n = 1'b1;
        step();
        check("post-reset waitrequest", 32'(waitrequest), 32'd1);

        // Full write then read back.
        do_access(1'b1, 1'b0, 17'h004, 32'h1234_5678, 4'hF, "wr004");
        do_access(1'b0, 1'b0, 17'h004, 32'h0, 4'h0, "rd004");

        // Byte-masked overwrite.
        do_access(1'b1, 1'b0, 17'h008, 32'hFFFF_FFFF, 4'hF, "wr008a");
        do_access(1'b1, 1'b0, 17'h008, 32'h0000_0000, 4'h5, "wr008b");
        do_access(1'b0, 1'b0, 17'h008, 32'h0, 4'h0, "rd008");
        check("byte-mask literal", model[2], 32'hFF00_FF00);

        // ID register ignores writes.
        do_access(1'b1, 1'b0, 17'h000, 32'h0, 4'hF, "wr000");
        do_access(1'b0, 1'b0, 17'h000, 32'h0, 4'h0, "rd000");

        // Out-of-range read.
        do_access(1'b0, 1'b0, 17'h200, 32'h0, 4'h0, "rd200");

        // Read and write together: write only, no read return.
        do_access(1'b1, 1'b1, 17'h00C, 32'hCAFE_F00D, 4'hF, "both00C");
        do_access(1'b0, 1'b0, 17'h00C, 32'h0, 4'h0, "rd00C");

        // Write issued while a read is pending stalls, and leaves the read data intact.
        address = 17'h00C;
        read    = 1'b1;
        n = 0;
        while (waitrequest === 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("stall rd accept-latency", 32'(n), 32'(WC + 1));
        step();
        read       = 1'b0;
        write      = 1'b1;
        writedata  = 32'h1111_1111;
        byteenable = 4'hF;
        flag = 1'b0;
        n = 0;
        while (readdatavalid !== 1'b1 && n < 64) begin
            if (waitrequest !== 1'b1) flag = 1'b1;
            step();
            n++;
        end
        check("stall waitrequest-held", 32'(flag), 32'd0);
        check("stall captured-data", readdata, 32'hCAFE_F00D);
        n = 0;
        while (waitrequest === 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("stall write accepted", 32'(n < 64), 32'd1);
        step();
        write = 1'b0;
        ref_write(3, 32'h1111_1111, 4'hF);
        do_access(1'b0, 1'b0, 17'h00C, 32'h0, 4'h0, "rd00C-after-stall");

        // Command dropped during the wait phase has no effect.
        address    = 17'h010;
        writedata  = 32'hDEAD_BEEF;
        byteenable = 4'hF;
        write      = 1'b1;
        step();
        write = 1'b0;
        flag = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (waitrequest !== 1'b1) flag = 1'b1;
            step();
        end
        check("drop never accepted", 32'(flag), 32'd0);
        do_access(1'b0, 1'b0, 17'h010, 32'h0, 4'h0, "rd010-after-drop");

        // Random traffic, including out-of-range indices and mixed commands.
        for (int it = 0; it < 60; it++) begin
            idx   = $urandom_range(0, NR + 7);
            is_wr = 1'($urandom_range(0, 1));
            do_access(is_wr, is_wr && ($urandom_range(0, 3) == 0), 17'(idx * 4),
                      $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        // Sweep of the whole register map against the model.
        for (int i = 0; i < NR; i++) begin
            do_access(1'b0, 1'b0, 17'(i * 4), 32'h0, 4'h0, "sweep");
        end

        // Reset while a read is pending aborts it and clears the registers.
        do_access(1'b1, 1'b0, 17'h004, 32'hA5A5_A5A5, 4'hF, "wr004-prereset");
        address = 17'h004;
        read    = 1'b1;
        n = 0;
        while (waitrequest === 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("rst rd accept-latency", 32'(n), 32'(WC + 1));
        step();
        read = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst waitrequest", 32'(waitrequest), 32'd1);
        check("rst readdatavalid", 32'(readdatavalid), 32'd0);
        check("rst readdata", readdata, 32'h0);
        ref_reset();
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst_n = 1'b1;
            if (readdatavalid !== 1'b0) flag = 1'b1;
            step();
        end
        check("rst no rdv pulse", 32'(flag), 32'd0);
        check("rst readdata held 0", readdata, 32'h0);
        do_access(1'b0, 1'b0, 17'h004, 32'h0, 4'h0, "rd004-after-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
